// File: rtl/seg_display_scheduler.sv
// 8-digit 7-seg scheduler: background bar vs timed hex overlay with req/ack; build option OVL_BLINK_EN blanks odd overlay frames.
// Latency: pins update 1 clk after each scan tick; ovl_ack/ovl_busy rise 1 clk after ovl_req is seen in BG.
// Backpressure: ovl_req is held off (not acked) while an overlay is showing; accepted in the first BG cycle.
module seg_display_scheduler #(
    parameter int DIV_N       = 5000,
    parameter int HOLD_FRAMES = 200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  bg_seq,
    input  logic        ovl_req,
    input  logic [31:0] ovl_data,
    output logic        ovl_ack,
    output logic        ovl_busy,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN
);

    localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
    localparam int FW       = $clog2(HOLD_EFF + 1);
    localparam int DW       = (DIV_N > 1) ? $clog2(DIV_N) : 1;

    typedef enum logic {
        ST_BG   = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_div_cnt;
    logic [2:0]      r_dig_idx;
    logic [FW-1:0]   r_frame_cnt;
    logic [FW-1:0]   w_frame_cnt_nxt;
    logic [31:0]     r_ovl_data;
    logic            r_ovl_ack;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;
    logic            w_tick;
    logic            w_frame_end;
    logic            w_accept;
    logic [3:0]      w_nibble;
    logic [6:0]      w_hex_seg;
    logic [6:0]      w_seg_nxt;

    assign w_tick      = (r_div_cnt == DW'(DIV_N - 1));
    assign w_frame_end = w_tick && (r_dig_idx == 3'd7);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_BG;
            r_frame_cnt <= '0;
            r_ovl_data  <= '0;
            r_ovl_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_ovl_ack   <= w_accept;
            if (w_accept) begin
                r_ovl_data <= ovl_data;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_accept        = 1'b0;
        case (r_state)
            ST_BG: begin
                if (ovl_req) begin
                    w_accept        = 1'b1;
                    w_frame_cnt_nxt = '0;
                    w_state_nxt     = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_frame_end) begin
                    if (r_frame_cnt == FW'(HOLD_EFF - 1)) begin
                        w_state_nxt = ST_BG;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_BG;
        endcase
    end

    assign w_nibble = r_ovl_data[{r_dig_idx, 2'b00} +: 4];

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    always_comb begin
        w_hex_seg = 7'h7F;
        case (w_nibble)
            4'h0: w_hex_seg = 7'h40;
            4'h1: w_hex_seg = 7'h79;
            4'h2: w_hex_seg = 7'h24;
            4'h3: w_hex_seg = 7'h30;
            4'h4: w_hex_seg = 7'h19;
            4'h5: w_hex_seg = 7'h12;
            4'h6: w_hex_seg = 7'h02;
            4'h7: w_hex_seg = 7'h78;
            4'h8: w_hex_seg = 7'h00;
            4'h9: w_hex_seg = 7'h10;
            4'hA: w_hex_seg = 7'h08;
            4'hB: w_hex_seg = 7'h03;
            4'hC: w_hex_seg = 7'h46;
            4'hD: w_hex_seg = 7'h21;
            4'hE: w_hex_seg = 7'h06;
            4'hF: w_hex_seg = 7'h0E;
            default: w_hex_seg = 7'h7F;
        endcase
    end

    always_comb begin
        w_seg_nxt = 7'h7F;
        if (r_state == ST_SHOW) begin
`ifdef OVL_BLINK_EN
            w_seg_nxt = r_frame_cnt[0] ? 7'h7F : w_hex_seg;
`else
            w_seg_nxt = w_hex_seg;
`endif
        end else begin
            w_seg_nxt = bg_seq[r_dig_idx] ? 7'h00 : 7'h7F;
        end
    end

    // Anode and segments for the incoming digit are registered together so a slot never ghosts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dig_idx <= 3'd0;
            r_an      <= 8'hFF;
            r_seg     <= 7'h7F;
        end else if (w_tick) begin
            r_dig_idx <= r_dig_idx + 3'd1;
            r_an      <= ~(8'd1 << r_dig_idx);
            r_seg     <= w_seg_nxt;
        end
    end

    assign ovl_ack  = r_ovl_ack;
    assign ovl_busy = (r_state == ST_SHOW);
    assign AN       = r_an;
    assign CA       = r_seg[0];
    assign CB       = r_seg[1];
    assign CC       = r_seg[2];
    assign CD       = r_seg[3];
    assign CE       = r_seg[4];
    assign CF       = r_seg[5];
    assign CG       = r_seg[6];
    assign DP       = 1'b1;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: a slot/frame-level reference model queues the expected
// pin state per clock; an independent monitor pops and compares on every falling edge.
module tb_seg_display_scheduler;

    localparam int DIV_N = 4;
    localparam int HOLD  = 3;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  bg_seq    = 8'h00;
    logic        ovl_req   = 1'b0;
    logic [31:0] ovl_data  = 32'h0;
    logic        ovl_ack, ovl_busy;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0]  AN;

    seg_display_scheduler #(.DIV_N(DIV_N), .HOLD_FRAMES(HOLD)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bg_seq(bg_seq),
        .ovl_req(ovl_req), .ovl_data(ovl_data), .ovl_ack(ovl_ack), .ovl_busy(ovl_busy),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP), .AN(AN)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        logic       busy;
    } exp_t;

    localparam exp_t RST_OUT = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, ack: 1'b0, busy: 1'b0};

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Lit segments per hex glyph, by letter.
    string GLYPHS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input int n);
        logic [6:0] p;
        string      s;
        int         idx;
        p = 7'h7F;
        s = GLYPHS[n];
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s.getc(i)) - 97;
            p[idx[2:0]] = 1'b0;
        end
        return p;
    endfunction

    // Reference model: slot number from cycles since reset, overlay as a countdown of whole frames.
    initial begin
        int          k;
        bit          active;
        bit          nxt_active;
        int          frames;
        int          d;
        logic [31:0] data_l;
        exp_t        o;
        k = 0; active = 0; frames = 0; data_l = '0; o = RST_OUT;
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                k = 0; active = 0; frames = 0; data_l = '0; o = RST_OUT;
            end else begin
                k++;
                o.ack = 1'b0;
                nxt_active = active;
                if (k % DIV_N == 0) begin
                    d = ((k / DIV_N) - 1) % 8;
                    o.an = ~(8'd1 << d);
                    if (active) begin
`ifdef OVL_BLINK_EN
                        o.seg = (frames % 2 == 1) ? 7'h7F : glyph(int'(data_l[4*d +: 4]));
`else
                        o.seg = glyph(int'(data_l[4*d +: 4]));
`endif
                        if (d == 7) begin
                            frames++;
                            if (frames == HOLD) nxt_active = 0;
                        end
                    end else begin
                        o.seg = bg_seq[d] ? 7'h00 : 7'h7F;
                    end
                end
                if (!active && ovl_req) begin
                    o.ack = 1'b1;
                    data_l = ovl_data;
                    frames = 0;
                    nxt_active = 1;
                end
                active = nxt_active;
                o.busy = active;
            end
            exp_q.push_back(o);
        end
    end

    // Async reset mid-cycle: the entry queued for this cycle becomes the reset state.
    initial begin
        forever begin
            @(negedge sys_rst_n);
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = RST_OUT;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{an: AN, seg: {CG, CF, CE, CD, CC, CB, CA}, dp: DP, ack: ovl_ack, busy: ovl_busy};
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL pins cyc=%0d got an=%h seg=%h dp=%b ack=%b busy=%b want an=%h seg=%h dp=%b ack=%b busy=%b",
                             cyc, a.an, a.seg, a.dp, a.ack, a.busy, e.an, e.seg, e.dp, e.ack, e.busy);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic request(input logic [31:0] d, input int budget);
        bit got;
        got = 0;
        ovl_data = d;
        ovl_req  = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            step(1);
            if (ovl_ack) got = 1;
        end
        ovl_req  = 1'b0;
        ovl_data = $urandom;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL ack_timeout got no ack within %0d cycles, want ack", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (ovl_busy && i < budget) begin
            step(1);
            i++;
        end
        n_checks++;
        if (ovl_busy) begin
            n_errors++;
            $display("FAIL busy_timeout got busy=1 after %0d cycles, want 0", budget);
        end
    endtask

    initial begin
        int r;
        step(3);
        bg_seq    = 8'h05;
        sys_rst_n = 1'b1;
        step(40);

        request(32'h7654_3210, 10);
        step(110);

        request(32'hFEDC_BA98, 10);
        step(20);
        request(32'h0A1B_2C3D, 200);
        wait_idle(200);
        step(10);

        for (int it = 0; it < 40; it++) begin
            bg_seq = 8'($urandom);
            r = $urandom_range(0, 3);
            case (r)
                0: step($urandom_range(1, 20));
                1: request($urandom, 200);
                2: begin
                    ovl_data = $urandom;
                    ovl_req  = 1'b1;
                    step($urandom_range(1, 3));
                    ovl_req  = 1'b0;
                    step($urandom_range(1, 10));
                end
                default: step($urandom_range(1, 3));
            endcase
        end
        wait_idle(200);

        bg_seq = 8'hA3;
        request(32'h1357_9BDF, 10);
        step(10);
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        step(45);

        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
